// File: rtl/fifo_pkg.sv
// Shared definitions for the narrowing FIFO: default sizes, width helpers
// and the lane selector used to slice a stored word into output lanes.
package fifo_pkg;

    localparam int DEF_IN_W   = 16;
    localparam int DEF_OUT_W  = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int LANE_MAX_W = 1024;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int calc_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Lane idx counts consumption order; lsb_first decides which physical lane that maps to.
    function automatic logic [LANE_MAX_W-1:0] lane_sel(
        input logic [LANE_MAX_W-1:0] word,
        input int                    idx,
        input bit                    lsb_first,
        input int                    out_w,
        input int                    ratio
    );
        int pos;
        pos = lsb_first ? idx : (ratio - 1 - idx);
        return word >> (pos * out_w);
    endfunction

endpackage

// File: rtl/fifo_width_conv_if.sv
// Producer/consumer handshake bundle for fifo_width_conv, including flush
// and the fill-level status outputs.
interface fifo_width_conv_if
    import fifo_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int RATIO = calc_ratio(IN_W, OUT_W);
    localparam int CW    = clog2(DEPTH + 1);
    localparam int LW    = clog2(RATIO);

    logic             flush;
    logic             input_valid;
    logic             input_enable;
    logic [IN_W-1:0]  data_in;
    logic             output_valid;
    logic             output_enable;
    logic [OUT_W-1:0] data_out;
    logic [CW-1:0]    word_count;
    logic [LW-1:0]    lane_idx;
    logic             almost_full;

    modport master (
        output flush,
        output input_valid,
        input  input_enable,
        output data_in,
        input  output_valid,
        output output_enable,
        input  data_out,
        input  word_count,
        input  lane_idx,
        input  almost_full
    );

    modport slave (
        input  flush,
        input  input_valid,
        output input_enable,
        input  data_in,
        output output_valid,
        input  output_enable,
        output data_out,
        output word_count,
        output lane_idx,
        output almost_full
    );

endinterface

// File: rtl/fifo_mem_2p.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_mem_2p
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_width_conv.sv
// Narrowing FIFO: stores IN_W-bit words and emits them as RATIO lanes of
// OUT_W bits with first-word fall-through on the read side.
module fifo_width_conv
    import fifo_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LSB_FIRST = 1,
    parameter int AFULL_TH  = DEPTH - 2
) (
    input logic               clk,
    input logic               rst,
    fifo_width_conv_if.slave  bus
);

    localparam int RATIO = calc_ratio(IN_W, OUT_W);
    localparam int AW    = clog2(DEPTH);
    localparam int CW    = clog2(DEPTH + 1);
    localparam int LW    = clog2(RATIO);

    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_TH);

    generate
        if (IN_W % OUT_W != 0) begin : g_bad_width
            $error("fifo_width_conv: IN_W must be a multiple of OUT_W");
        end
        if (RATIO < 2) begin : g_bad_ratio
            $error("fifo_width_conv: IN_W/OUT_W must be at least 2");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fifo_width_conv: DEPTH must be a power of two >= 2");
        end
        if (AFULL_TH > DEPTH || AFULL_TH < 0) begin : g_bad_afull
            $error("fifo_width_conv: AFULL_TH must lie in 0..DEPTH");
        end
        if (IN_W > LANE_MAX_W) begin : g_bad_max
            $error("fifo_width_conv: IN_W exceeds LANE_MAX_W");
        end
    endgenerate

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [LW-1:0]         lane;
    logic [IN_W-1:0]       head_word;
    logic [LANE_MAX_W-1:0] sel_full;
    logic                  unused_sel_bits;

    logic do_write;
    logic do_read;
    logic do_pop;
    logic clear;

    assign clear    = rst | bus.flush;
    assign do_write = bus.input_valid & bus.input_enable;
    assign do_read  = bus.output_valid & bus.output_enable;
    assign do_pop   = do_read & (lane == LAST_LANE);

    // Flush shares the reset path: in-flight handshakes that cycle are dropped.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            lane   <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_read) begin
                if (lane == LAST_LANE) begin
                    lane   <= '0;
                    rd_ptr <= rd_ptr + AW'(1);
                end else begin
                    lane <= lane + LW'(1);
                end
            end
            case ({do_write, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    fifo_mem_2p #(
        .DEPTH (DEPTH),
        .WIDTH (IN_W),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (do_write & ~clear),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (head_word)
    );

    assign sel_full = lane_sel(LANE_MAX_W'(head_word), int'(lane), LSB_FIRST != 0, OUT_W, RATIO);
    assign unused_sel_bits = ^sel_full[LANE_MAX_W-1:OUT_W];

    assign bus.input_enable = (count != FULL_CNT);
    assign bus.output_valid = (count != '0);
    assign bus.almost_full  = (count >= AFULL_CNT);
    assign bus.word_count   = count;
    assign bus.lane_idx     = lane;
    assign bus.data_out     = bus.output_valid ? sel_full[OUT_W-1:0] : '0;

endmodule
